// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu
//   Execute stage: operand forwarding, combinational ALU and an iterative
//   RV32M multiply/divide unit. The MDU takes a fixed XLEN+2 EX cycles per op
//   (one start cycle, XLEN iteration cycles, one result cycle). It stalls the
//   pipeline through mdu_busy and latches its forwarded operands at start,
//   because MEM/WB keep moving and the forward sources change during the stall.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   ALUCode_ex, ALUSrcA_ex/B_ex     ALU operation and operand selects
//   MDUValid_ex, MDUOp_ex           M-extension op valid, funct3
//   flush_ex                        kill the EX instruction
//   Imm_ex, PC_ex                   immediate, PC
//   rs1/rs2 Addr_ex, Data_ex        source addresses, register-file data
//   ALUResult_mem, RegWriteData_wb  forward sources
//   rdAddr_mem/_wb, RegWrite_mem/_wb destination address / write enable
//   ALUResult_ex                    ALU result, or MDU result while MDUValid_ex
//   MemWriteData_ex                 forwarded rs2
//   ALU_A, ALU_B                    ALU operands
//   mdu_busy                        stall request
//   mdu_done                        one-cycle pulse, MDU result on ALUResult_ex
//
// state | meaning
// IDLE  | waiting; an MDU op here starts (busy asserted) and latches operands
// RUN   | one shift-add / restoring-subtract step per cycle, XLEN cycles
// DONE  | result register presented, done pulses, pipeline advances

module ex_stage_mdu #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         ALUCode_ex,
   input  logic               ALUSrcA_ex,
   input  logic [1:0]         ALUSrcB_ex,
   input  logic               MDUValid_ex,
   input  logic [2:0]         MDUOp_ex,
   input  logic               flush_ex,
   input  logic [XLEN-1:0]    Imm_ex,
   input  logic [XLEN-1:0]    PC_ex,
   input  logic [RADDR_W-1:0] rs1Addr_ex,
   input  logic [RADDR_W-1:0] rs2Addr_ex,
   input  logic [XLEN-1:0]    rs1Data_ex,
   input  logic [XLEN-1:0]    rs2Data_ex,
   input  logic [XLEN-1:0]    ALUResult_mem,
   input  logic [XLEN-1:0]    RegWriteData_wb,
   input  logic [RADDR_W-1:0] rdAddr_mem,
   input  logic [RADDR_W-1:0] rdAddr_wb,
   input  logic               RegWrite_mem,
   input  logic               RegWrite_wb,
   output logic [XLEN-1:0]    ALUResult_ex,
   output logic [XLEN-1:0]    MemWriteData_ex,
   output logic [XLEN-1:0]    ALU_A,
   output logic [XLEN-1:0]    ALU_B,
   output logic               mdu_busy,
   output logic               mdu_done
);

   localparam int CNT_W = $clog2(XLEN);
   localparam int SH_W  = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_count;
   logic [XLEN-1:0]      r_hi;
   logic [XLEN-1:0]      r_lo;
   logic [XLEN-1:0]      r_b;
   logic [2:0]           r_op;
   logic                 r_neg_res;
   logic                 r_neg_rem;
   logic                 r_div0;
   logic [XLEN-1:0]      r_result;

   logic [XLEN-1:0]      w_fwd_a, w_fwd_b, w_alu;
   logic                 w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic [XLEN-1:0]      w_mag_a, w_mag_b;
   logic [SH_W-1:0]      w_shamt;
   logic [XLEN:0]        w_sum, w_rt;
   logic                 w_ge;
   logic [XLEN-1:0]      w_rsub, w_hi_nxt, w_lo_nxt;
   logic [2*XLEN-1:0]    w_prod, w_prod_s;
   logic [XLEN-1:0]      w_quot, w_rem, w_final;

   // Forwarding: MEM has priority over WB; x0 is never forwarded.
   always_comb begin
      w_fwd_a = rs1Data_ex;
      if (RegWrite_mem && rdAddr_mem != '0 && rdAddr_mem == rs1Addr_ex)
         w_fwd_a = ALUResult_mem;
      else if (RegWrite_wb && rdAddr_wb != '0 && rdAddr_wb == rs1Addr_ex)
         w_fwd_a = RegWriteData_wb;

      w_fwd_b = rs2Data_ex;
      if (RegWrite_mem && rdAddr_mem != '0 && rdAddr_mem == rs2Addr_ex)
         w_fwd_b = ALUResult_mem;
      else if (RegWrite_wb && rdAddr_wb != '0 && rdAddr_wb == rs2Addr_ex)
         w_fwd_b = RegWriteData_wb;
   end

   assign MemWriteData_ex = w_fwd_b;
   assign ALU_A = ALUSrcA_ex ? PC_ex : w_fwd_a;

   always_comb begin
      case (ALUSrcB_ex)
         2'd1:    ALU_B = Imm_ex;
         2'd2:    ALU_B = XLEN'(4);
         default: ALU_B = w_fwd_b;
      endcase
   end

   assign w_shamt = ALU_B[SH_W-1:0];

   always_comb begin
      case (ALUCode_ex)
         4'd0:    w_alu = ALU_A + ALU_B;
         4'd1:    w_alu = ALU_A - ALU_B;
         4'd2:    w_alu = ALU_A << w_shamt;
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, $signed(ALU_A) < $signed(ALU_B)};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, ALU_A < ALU_B};
         4'd5:    w_alu = ALU_A ^ ALU_B;
         4'd6:    w_alu = ALU_A >> w_shamt;
         4'd7:    w_alu = $unsigned($signed(ALU_A) >>> w_shamt);
         4'd8:    w_alu = ALU_A | ALU_B;
         4'd9:    w_alu = ALU_A & ALU_B;
         4'd10:   w_alu = ALU_B;
         default: w_alu = '0;
      endcase
   end

   // Operand signedness by funct3: MULH, MULHSU, DIV, REM treat rs1 as signed;
   // MULHSU keeps rs2 unsigned.
   assign w_sgn_a = (MDUOp_ex == 3'd1) || (MDUOp_ex == 3'd2) ||
                    (MDUOp_ex == 3'd4) || (MDUOp_ex == 3'd6);
   assign w_sgn_b = (MDUOp_ex == 3'd1) || (MDUOp_ex == 3'd4) || (MDUOp_ex == 3'd6);
   assign w_neg_a = w_sgn_a & w_fwd_a[XLEN-1];
   assign w_neg_b = w_sgn_b & w_fwd_b[XLEN-1];
   assign w_mag_a = w_neg_a ? -w_fwd_a : w_fwd_a;
   assign w_mag_b = w_neg_b ? -w_fwd_b : w_fwd_b;

   // One iteration of the unsigned core. Multiply: {hi,lo} holds partial
   // product and remaining multiplier bits. Divide: hi is the partial
   // remainder, lo shifts out dividend bits and shifts in quotient bits.
   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rt   = {r_hi, r_lo[XLEN-1]};
      w_ge   = (w_rt >= {1'b0, r_b});
      w_rsub = w_rt[XLEN-1:0] - r_b;
      if (r_op[2]) begin
         // when no subtract happens, w_rt < divisor so its top bit is zero
         w_hi_nxt = w_ge ? w_rsub : w_rt[XLEN-1:0];
         w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_hi_nxt = w_sum[XLEN:1];
         w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   // Sign fix-up and special cases applied to the final iteration's output.
   // Signed overflow (-2^(XLEN-1) / -1) falls out of the magnitude path:
   // quotient magnitude 2^(XLEN-1) with positive sign, remainder 0.
   always_comb begin
      w_prod   = {w_hi_nxt, w_lo_nxt};
      w_prod_s = r_neg_res ? -w_prod : w_prod;
      w_quot   = r_div0 ? '1 : (r_neg_res ? -w_lo_nxt : w_lo_nxt);
      w_rem    = r_neg_rem ? -w_hi_nxt : w_hi_nxt;
      case (r_op)
         3'd0:          w_final = w_prod_s[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:          w_final = w_prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:    w_final = w_quot;
         default:       w_final = w_rem;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_result  <= '0;
      end else if (flush_ex) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (MDUValid_ex) begin
                  r_state   <= S_RUN;
                  r_count   <= CNT_W'(XLEN-1);
                  r_hi      <= '0;
                  r_lo      <= w_mag_a;
                  r_b       <= w_mag_b;
                  r_op      <= MDUOp_ex;
                  r_neg_res <= w_neg_a ^ w_neg_b;
                  r_neg_rem <= w_neg_a;
                  r_div0    <= MDUOp_ex[2] && (w_fwd_b == '0);
               end
            end
            S_RUN: begin
               r_hi <= w_hi_nxt;
               r_lo <= w_lo_nxt;
               if (r_count == '0) begin
                  r_state  <= S_DONE;
                  r_result <= w_final;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Busy is combinational so the hazard unit holds the pipeline in the start
   // cycle; reset gates it so an in-flight request disappears immediately.
   assign mdu_busy = !reset && !flush_ex &&
                     ((r_state == S_RUN) || (r_state == S_IDLE && MDUValid_ex));
   assign mdu_done = (r_state == S_DONE);

   always_comb begin
      if (MDUValid_ex)
         ALUResult_ex = (r_state == S_DONE) ? r_result : '0;
      else
         ALUResult_ex = w_alu;
   end

endmodule
